// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// SEG_OFF    : all segments dark (active-low bus).
// SEG_x      : bit positions of segments a..g and the decimal point.
// SEG_HEX    : active-low 7-bit font for 0-F. Bit 0 is segment a.
//              b and d are drawn in lowercase.
package disp_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-seven-segment decoder with decimal point.
// nibble_i : hex value 0-F
// point_i  : decimal point request, active high
// seg_o    : {dp, g..a}, all active low
module hex7seg_dec
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       point_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o                = SEG_OFF;
    seg_o[SEG_G:SEG_A]   = SEG_HEX[nibble_i];
    seg_o[SEG_DP]        = ~point_i;
  end

endmodule

// File: rtl/disp_num_scan.sv
// Time-multiplexed hex seven-segment display driver.
// Latches DIGITS nibbles plus point/blank/leading-zero controls, then scans
// one digit per DIV-cycle slot onto a shared active-low segment bus. The
// first DEAD cycles of each slot keep all anodes off.
// clk        : system clock, all state on rising edge
// rst        : synchronous active-high reset
// data       : hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
// point      : decimal point request per digit, active high
// blank      : force digit dark, active high
// lz_en      : leading-zero suppression enable
// le         : 0 = capture inputs every cycle, 1 = hold latched values
// AN         : anode enables, active low (at most one low)
// SEGMENT    : {p, g..a}, active low
// scan_idx   : digit currently owning the scan slot
// frame_tick : one-cycle pulse when the scan wraps back to digit 0
module disp_num_scan
  import disp_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int DEAD   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       data,
  input  logic [DIGITS-1:0]         point,
  input  logic [DIGITS-1:0]         blank,
  input  logic                      lz_en,
  input  logic                      le,
  output logic [DIGITS-1:0]         AN,
  output logic [7:0]                SEGMENT,
  output logic [$clog2(DIGITS)-1:0] scan_idx,
  output logic                      frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Latch stage
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   point_q, point_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                lz_q, lz_d;

  // Scan control
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tick_q, tick_d;

  // Output stage
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  logic [DIGITS-1:0]   supp;
  logic                zero_run;
  logic                cnt_last;
  logic [3:0]          cur_nib;
  logic [7:0]          cur_seg;

  assign cur_nib = data_q[{idx_q, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nibble_i (cur_nib),
    .point_i  (point_q[idx_q]),
    .seg_o    (cur_seg)
  );

  // Walk from the most significant digit down; zero_run stays set while
  // every nibble seen so far is zero. Digit 0 is always shown.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (data_q[4*i +: 4] == 4'h0);
      supp[i]  = blank_q[i] | (lz_q & (i != 0) & zero_run);
    end
  end

  always_comb begin
    data_d   = le ? data_q  : data;
    point_d  = le ? point_q : point;
    blank_d  = le ? blank_q : blank;
    lz_d     = le ? lz_q    : lz_en;

    cnt_last = (cnt_q == CNT_LAST);
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    tick_d   = cnt_last && (idx_q == IDX_LAST);

    // Output reflects this cycle's cnt/idx, so it lands one cycle later.
    an_d  = '1;
    seg_d = SEG_OFF;
    if (!(cnt_q < DEAD_C) && !supp[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      point_q <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
    end else begin
      data_q  <= data_d;
      point_q <= point_d;
      blank_q <= blank_d;
      lz_q    <= lz_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign AN         = an_q;
  assign SEGMENT    = seg_q;
  assign scan_idx   = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_num_scan.sv
// Directed bench for disp_num_scan with DIGITS=4, DIV=8, DEAD=2.
// Each cycle the expected outputs are pushed to a scoreboard queue before the
// clock edge and popped/compared 1 time unit after it.
module tb_disp_num_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int DEAD   = 2;
  localparam int FRAME  = DIGITS * DIV;

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  point;
  logic [3:0]  blank;
  logic        lz_en;
  logic        le;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic [1:0]  scan_idx;
  logic        frame_tick;

  disp_num_scan #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .point      (point),
    .blank      (blank),
    .lz_en      (lz_en),
    .le         (le),
    .AN         (AN),
    .SEGMENT    (SEGMENT),
    .scan_idx   (scan_idx),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    int         idx;
    logic       ft;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Bench-side picture of the latched inputs.
  logic [15:0] m_data;
  logic [3:0]  m_point;
  logic [3:0]  m_blank;
  logic        m_lz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_supp(input int k);
    return m_blank[k] || (m_lz && k != 0 && ((m_data >> (4 * k)) == 16'h0));
  endfunction

  task automatic tick();
    exp_t e;
    exp_t g;
    int   c;
    int   k;
    if (rst) begin
      e.an = 4'hF; e.seg = 8'hFF; e.idx = 0; e.ft = 1'b0;
    end else begin
      c = cyc % DIV;
      k = (cyc / DIV) % DIGITS;
      if (c < DEAD || m_supp(k)) begin
        e.an  = 4'hF;
        e.seg = 8'hFF;
      end else begin
        e.an  = 4'hF & ~(4'b0001 << k);
        e.seg = {~m_point[k], FONT[m_data[4*k +: 4]]};
      end
      e.idx = ((cyc + 1) / DIV) % DIGITS;
      e.ft  = ((cyc % FRAME) == FRAME - 1);
    end
    sb_q.push_back(e);

    if (rst) begin
      m_data = '0; m_point = '0; m_blank = '0; m_lz = 1'b0;
    end else if (!le) begin
      m_data = data; m_point = point; m_blank = blank; m_lz = lz_en;
    end

    @(posedge clk);
    #1;
    cyc = rst ? 0 : cyc + 1;

    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      g = sb_q.pop_front();
      chk("AN",         {28'd0, AN},          {28'd0, g.an});
      chk("SEGMENT",    {24'd0, SEGMENT},     {24'd0, g.seg});
      chk("scan_idx",   {30'd0, scan_idx},    32'(g.idx));
      chk("frame_tick", {31'd0, frame_tick},  {31'd0, g.ft});
      chk("one_anode",  32'($countones(~AN) <= 1), 32'd1);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; data = 16'h1234; point = 4'h0; blank = 4'h0;
    lz_en = 1'b0; le = 1'b0;
    m_data = '0; m_point = '0; m_blank = '0; m_lz = 1'b0;

    // Reset held for three cycles.
    run(3);

    // Plain scan of 1234 across more than one frame.
    rst = 1'b0;
    run(FRAME + 8);

    // Font sweep through the remaining glyphs.
    data = 16'h5678; run(FRAME);
    data = 16'h9ABC; run(FRAME);
    data = 16'hDEF0; run(FRAME);

    // Leading-zero suppression.
    data = 16'h0070; lz_en = 1'b1; run(FRAME);
    data = 16'h0000; run(FRAME);
    data = 16'h0305; run(FRAME);

    // Hold: new inputs ignored while le=1.
    le = 1'b1; data = 16'hFFFF; lz_en = 1'b0; point = 4'hF; blank = 4'hF;
    run(FRAME);

    // Release the latch and request a point on digit 1.
    le = 1'b0; data = 16'h1234; point = 4'b0010; blank = 4'h0;
    run(FRAME);

    // Blank digit 2.
    point = 4'h0; blank = 4'b0100; run(FRAME);

    // Move into the middle of digit 2's slot, then reset mid-scan.
    blank = 4'h0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (((cyc / DIV) % DIGITS) == 2 && (cyc % DIV) == 4) break;
      tick();
    end
    chk("reach_digit2", 32'((cyc / DIV) % DIGITS), 32'd2);
    rst = 1'b1; run(1);
    rst = 1'b0; run(FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
